// File: rtl/jlm_pkg.sv
//------------------------------------------------------------------------------
// jlm_pkg : shared types and constants for the junction lamp safety monitor
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package jlm_pkg;

  localparam logic [2:0] JLM_NONE      = 3'd0;
  localparam logic [2:0] JLM_DARK      = 3'd1;
  localparam logic [2:0] JLM_MULTI     = 3'd2;
  localparam logic [2:0] JLM_SEQ       = 3'd3;
  localparam logic [2:0] JLM_YEL_SHORT = 3'd4;
  localparam logic [2:0] JLM_YEL_LONG  = 3'd5;
  localparam logic [2:0] JLM_CONFLICT  = 3'd6;

  typedef enum logic [1:0] {
    TRK_UNK = 2'd0,
    TRK_RED = 2'd1,
    TRK_GRN = 2'd2,
    TRK_YEL = 2'd3
  } trkState_t;

  localparam int LAMP_R = 2;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 0;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;
  localparam int NUM_DIR = 4;

  // Fault-vector bit index doubles as same-cycle priority rank (0 = highest)
  localparam int FV_MULTI     = 0;
  localparam int FV_DARK      = 1;
  localparam int FV_SEQ       = 2;
  localparam int FV_YEL_LONG  = 3;
  localparam int FV_YEL_SHORT = 4;
  localparam int FV_W         = 5;

  function automatic logic [2:0] fvCode(input int idx);
    case (idx)
      FV_MULTI:     return JLM_MULTI;
      FV_DARK:      return JLM_DARK;
      FV_SEQ:       return JLM_SEQ;
      FV_YEL_LONG:  return JLM_YEL_LONG;
      FV_YEL_SHORT: return JLM_YEL_SHORT;
      default:      return JLM_NONE;
    endcase
  endfunction

  function automatic logic [1:0] dirOf(input int idx);
    case (idx)
      0:       return DIR_N;
      1:       return DIR_E;
      2:       return DIR_S;
      default: return DIR_W;
    endcase
  endfunction

  function automatic logic legalStep(input trkState_t from, input trkState_t to);
    return (from == TRK_RED && to == TRK_GRN) ||
           (from == TRK_GRN && to == TRK_YEL) ||
           (from == TRK_YEL && to == TRK_RED);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jlm_approach_tracker.sv
//------------------------------------------------------------------------------
// jlm_approach_tracker : per-approach lamp sequence tracker and yellow dwell check
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module jlm_approach_tracker import jlm_pkg::*; #(
  parameter int YELLOW_MIN = 3,
  parameter int YELLOW_MAX = 10,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [2:0]       i_lamp,
  output logic [FV_W-1:0]  o_faultVec
);

  trkState_t        r_state;
  trkState_t        w_nextState;
  trkState_t        w_pat;
  logic [CNT_W-1:0] r_yelCnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_dark;
  logic             w_multi;
  logic             w_oneHot;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= TRK_UNK;
      r_yelCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_yelCnt <= w_nextCnt;
    end
  end

  always_comb begin
    w_dark   = (i_lamp == 3'b000);
    w_multi  = ((i_lamp & (i_lamp - 3'd1)) != 3'b000);
    w_oneHot = !w_dark && !w_multi;

    w_pat = TRK_UNK;
    if (w_oneHot) begin
      if (i_lamp[LAMP_R])      w_pat = TRK_RED;
      else if (i_lamp[LAMP_Y]) w_pat = TRK_YEL;
      else                     w_pat = TRK_GRN;
    end

    o_faultVec = '0;
    if (i_en) begin
      o_faultVec[FV_DARK]      = w_dark;
      o_faultVec[FV_MULTI]     = w_multi;
      o_faultVec[FV_SEQ]       = w_oneHot && (r_state != TRK_UNK) && (w_pat != r_state) &&
                                 !legalStep(r_state, w_pat);
      o_faultVec[FV_YEL_LONG]  = (r_state == TRK_YEL) && (w_pat == TRK_YEL) &&
                                 (r_yelCnt == CNT_W'(YELLOW_MAX));
      o_faultVec[FV_YEL_SHORT] = (r_state == TRK_YEL) && (w_pat == TRK_RED) &&
                                 (r_yelCnt < CNT_W'(YELLOW_MIN));
    end

    // A faulting approach holds its state so the violation stays visible
    w_nextState = r_state;
    if (!i_en || i_clr)
      w_nextState = TRK_UNK;
    else if ((o_faultVec == '0) && w_oneHot)
      w_nextState = w_pat;

    w_nextCnt = '0;
    if (w_nextState == TRK_YEL) begin
      if (r_state != TRK_YEL)
        w_nextCnt = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (&r_yelCnt)
        w_nextCnt = r_yelCnt;
      else
        w_nextCnt = r_yelCnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/junction_light_monitor.sv
//------------------------------------------------------------------------------
// junction_light_monitor : first-fault safety monitor for a 4-approach junction
// Optional safe-mode flasher enabled by defining JLM_FLASH_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module junction_light_monitor import jlm_pkg::*; #(
  parameter int YELLOW_MIN = 3,
  parameter int YELLOW_MAX = 10,
  parameter int CNT_W      = 16,
  parameter int FLASH_DIV  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        CLR_FAULT,
  input  logic [11:0] LIGHTS,
  output logic        FAULT,
  output logic [2:0]  FAULT_CODE,
  output logic [1:0]  FAULT_DIR,
  output logic        FLASH
);

  logic [11:0]     r_lightsQ;
  logic [2:0]      w_lamp  [NUM_DIR];
  logic [FV_W-1:0] w_fv    [NUM_DIR];
  logic [NUM_DIR-1:0] w_nonRed;
  logic [2:0]      w_nonRedCnt;
  logic [2:0]      w_code;
  logic [1:0]      w_dir;
  logic            w_setFault;
  logic            r_fault;
  logic [2:0]      r_code;
  logic [1:0]      r_dir;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_lightsQ <= '0;
    else     r_lightsQ <= LIGHTS;
  end

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_trk
    assign w_lamp[g]   = r_lightsQ[3*g +: 3];
    assign w_nonRed[g] = (w_lamp[g] == 3'b010) || (w_lamp[g] == 3'b001);

    jlm_approach_tracker #(
      .YELLOW_MIN (YELLOW_MIN),
      .YELLOW_MAX (YELLOW_MAX),
      .CNT_W      (CNT_W)
    ) u_trk (
      .CLK        (CLK),
      .RST        (RST),
      .i_en       (EN),
      .i_clr      (CLR_FAULT),
      .i_lamp     (w_lamp[g]),
      .o_faultVec (w_fv[g])
    );
  end

  // Descending loops: the last hit written is the highest-priority code at the lowest index
  always_comb begin
    w_code      = JLM_NONE;
    w_dir       = DIR_N;
    w_nonRedCnt = 3'd0;
    for (int k = FV_W - 1; k >= 0; k--) begin
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
        if (w_fv[i][k]) begin
          w_code = fvCode(k);
          w_dir  = dirOf(i);
        end
      end
    end
    for (int i = 0; i < NUM_DIR; i++)
      w_nonRedCnt = w_nonRedCnt + {2'b00, w_nonRed[i]};
    if (EN && (w_nonRedCnt >= 3'd2)) begin
      w_code = JLM_CONFLICT;
      for (int i = NUM_DIR - 1; i >= 0; i--)
        if (w_nonRed[i]) w_dir = dirOf(i);
    end
  end

  assign w_setFault = !r_fault && (w_code != JLM_NONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fault <= 1'b0;
      r_code  <= JLM_NONE;
      r_dir   <= DIR_N;
    end else if (CLR_FAULT) begin
      r_fault <= 1'b0;
      r_code  <= JLM_NONE;
      r_dir   <= DIR_N;
    end else if (w_setFault) begin
      r_fault <= 1'b1;
      r_code  <= w_code;
      r_dir   <= w_dir;
    end
  end

  assign FAULT      = r_fault;
  assign FAULT_CODE = r_code;
  assign FAULT_DIR  = r_dir;

`ifdef JLM_FLASH_EN
  localparam int DIV_W = $clog2(FLASH_DIV + 1);

  logic             r_flash;
  logic [DIV_W-1:0] r_div;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_flash <= 1'b0;
      r_div   <= '0;
    end else if (CLR_FAULT || !r_fault) begin
      r_flash <= !CLR_FAULT && w_setFault;
      r_div   <= '0;
    end else if (r_div == DIV_W'(FLASH_DIV - 1)) begin
      r_flash <= !r_flash;
      r_div   <= '0;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

  assign FLASH = r_flash;
`else
  logic w_unusedFlashDiv;
  assign w_unusedFlashDiv = (FLASH_DIV != 0);
  assign FLASH = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_junction_light_monitor.sv
//------------------------------------------------------------------------------
// tb_junction_light_monitor : directed self-checking bench for junction_light_monitor
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_junction_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        CLR_FAULT;
  logic [11:0] LIGHTS;
  logic        FAULT;
  logic [2:0]  FAULT_CODE;
  logic [1:0]  FAULT_DIR;
  logic        FLASH;

  int checks   = 0;
  int failures = 0;

  junction_light_monitor #(
    .YELLOW_MIN (3),
    .YELLOW_MAX (10),
    .CNT_W      (16),
    .FLASH_DIV  (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .CLR_FAULT  (CLR_FAULT),
    .LIGHTS     (LIGHTS),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE),
    .FAULT_DIR  (FAULT_DIR),
    .FLASH      (FLASH)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] mk(input logic [2:0] n, input logic [2:0] e,
                                     input logic [2:0] s, input logic [2:0] w);
    return {w, s, e, n};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkF(input string tag, input logic f, input logic [2:0] code, input logic [1:0] dir);
    chk({tag, "_fault"}, {7'd0, FAULT}, {7'd0, f});
    chk({tag, "_code"},  {5'd0, FAULT_CODE}, {5'd0, code});
    chk({tag, "_dir"},   {6'd0, FAULT_DIR}, {6'd0, dir});
  endtask

  task automatic clearFault();
    LIGHTS    = mk(R, R, R, R);
    CLR_FAULT = 1'b1;
    tick();
    CLR_FAULT = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLR_FAULT = 1'b0; LIGHTS = 12'h000;
    tick(2);
    chkF("reset", 1'b0, 3'd0, 2'd0);
    chk("reset_flash", {7'd0, FLASH}, 8'd0);
    RST = 1'b0;

    // Idle with monitor disabled and all lamps dark
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_fault", {7'd0, FAULT}, 8'd0);
    end

    // Legal N cycle R5 G8 Y5 R with others red
    LIGHTS = mk(R, R, R, R);
    tick();
    EN = 1'b1;
    tick(5);
    LIGHTS = mk(G, R, R, R); tick(8);
    LIGHTS = mk(Y, R, R, R); tick(5);
    LIGHTS = mk(R, R, R, R); tick(5);
    chkF("legal", 1'b0, 3'd0, 2'd0);

    // Short yellow: 2 cycles then red
    LIGHTS = mk(G, R, R, R); tick(3);
    LIGHTS = mk(Y, R, R, R); tick(2);
    LIGHTS = mk(R, R, R, R); tick();
    chk("yshort_early", {7'd0, FAULT}, 8'd0);
    tick();
    chkF("yshort", 1'b1, 3'd4, 2'd0);

    // Long yellow: 10 samples legal, 11th sample faults one edge later
    clearFault();
    chkF("clr1", 1'b0, 3'd0, 2'd0);
    LIGHTS = mk(G, R, R, R); tick(2);
    LIGHTS = mk(Y, R, R, R); tick(11);
    chk("ylong_early", {7'd0, FAULT}, 8'd0);
    tick();
    chkF("ylong", 1'b1, 3'd5, 2'd0);

    // Conflict N and E green
    clearFault();
    tick(2);
    LIGHTS = mk(G, G, R, R); tick();
    chk("conf_early", {7'd0, FAULT}, 8'd0);
    tick();
    chkF("conflict", 1'b1, 3'd6, 2'd0);
    LIGHTS = mk(G, G, D, R); tick(3);
    chkF("first_wins", 1'b1, 3'd6, 2'd0);

    // Multi lamp on W
    clearFault();
    tick();
    LIGHTS = mk(R, R, R, 3'b110); tick();
    chk("multi_early", {7'd0, FAULT}, 8'd0);
    tick();
    chkF("multi_w", 1'b1, 3'd2, 2'd3);

    // Priority: MULTI on E and W beats DARK on N; tie goes to E
    clearFault();
    tick();
    LIGHTS = mk(D, 3'b101, R, 3'b110); tick(2);
    chkF("prio", 1'b1, 3'd2, 2'd1);

    // Sequence error G->R on N
    clearFault();
    tick();
    LIGHTS = mk(G, R, R, R); tick(2);
    LIGHTS = mk(R, R, R, R); tick();
    chk("seq_early", {7'd0, FAULT}, 8'd0);
    tick();
    chkF("seq", 1'b1, 3'd3, 2'd0);

    // Fault latch retained while disabled
    EN = 1'b0;
    tick(3);
    chkF("en_low_hold", 1'b1, 3'd3, 2'd0);
    EN = 1'b1;

    // Clear in the same cycle as a detected fault
    clearFault();
    LIGHTS = mk(G, R, R, R); tick(2);
    LIGHTS = mk(R, R, R, R); tick();
    CLR_FAULT = 1'b1;
    tick();
    CLR_FAULT = 1'b0;
    chkF("clr_wins", 1'b0, 3'd0, 2'd0);
    tick();
    chkF("clr_resync", 1'b0, 3'd0, 2'd0);

    // Dark on E, then flasher behaviour
    LIGHTS = mk(R, D, R, R); tick();
    chk("dark_early", {7'd0, FAULT}, 8'd0);
    tick();
    chkF("dark_e", 1'b1, 3'd1, 2'd1);
`ifdef JLM_FLASH_EN
    chk("flash_start", {7'd0, FLASH}, 8'd1);
    tick(7);
    chk("flash_hold", {7'd0, FLASH}, 8'd1);
    tick();
    chk("flash_low", {7'd0, FLASH}, 8'd0);
    tick(8);
    chk("flash_high", {7'd0, FLASH}, 8'd1);
`else
    tick(8);
    chk("flash_off", {7'd0, FLASH}, 8'd0);
`endif

    // Asynchronous reset mid-operation
    #2 RST = 1'b1;
    #1;
    chkF("async_rst", 1'b0, 3'd0, 2'd0);
    chk("async_rst_flash", {7'd0, FLASH}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
